multi_debounce: RTL

- N-channel switch debouncer; the parametrised successor of the single-channel debouncer.
- Each channel filters one raw switch input and drives a clean level.
- Each channel also emits one-cycle rise/fall pulses.
- Sits between board-level switch/button pins and control logic (e.g. FIFO push/pop triggers), in the `clk` domain.

---
 rtl/multi_debounce_pkg.sv | 9 +
 rtl/debounce_ch.sv | 85 ++++++++
 rtl/multi_debounce.sv | 46 ++++
 3 files changed

// File: rtl/multi_debounce_pkg.sv
// Shared types and default sizing for the multi-channel switch debouncer.
package multi_debounce_pkg;

    typedef enum logic {STABLE = 1'b0, FILTER = 1'b1} db_state_e;

    localparam int DB_CHANNELS_DEF      = 4;
    localparam int DB_STABLE_CYCLES_DEF = 10;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: optional 2-flop synchronizer, STABLE/FILTER FSM, counter,
// registered level and rise/fall pulses. Synchronizer enabled by MULTI_DEBOUNCE_SYNC_EN.
module debounce_ch
    import multi_debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    parameter logic RESET_VAL     = 1'b0,
    parameter int   CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic change_nxt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic s;

`ifdef MULTI_DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= {2{RESET_VAL}};
        else     sync_q <= {sync_q[0], sw};
    end

    assign s = sync_q[1];
`else
    assign s = sw;
`endif

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_d, rise_d, fall_d;
    logic             done;

    // Accept the new level on the STABLE_CYCLES-th consecutive differing sample.
    assign done       = (state_q == FILTER) && (s != db) && (cnt_q == CNT_LAST);
    assign change_nxt = done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            db      <= RESET_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db      <= db_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            STABLE: begin
                if (s != db) begin
                    state_d = FILTER;
                    cnt_d   = CNT_W'(1);
                end
            end
            FILTER: begin
                if (s == db || cnt_q == CNT_LAST) state_d = STABLE;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = STABLE;
        endcase
    end

    always_comb begin
        db_d   = done ? s : db;
        rise_d = done &  s;
        fall_d = done & ~s;
    end

endmodule

// File: rtl/multi_debounce.sv
// N-channel switch debouncer with per-channel rise/fall pulses and a combined change flag.
// Optional input synchronizers via MULTI_DEBOUNCE_SYNC_EN.
module multi_debounce
    import multi_debounce_pkg::*;
#(
    parameter int   CHANNELS      = DB_CHANNELS_DEF,
    parameter int   STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    parameter logic RESET_VAL     = 1'b0,
    parameter int   CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sw_i,
    output logic [CHANNELS-1:0] db_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                any_change_o
);

    logic [CHANNELS-1:0] chg_nxt;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            debounce_ch #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .RESET_VAL     (RESET_VAL),
                .CNT_W         (CNT_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .sw         (sw_i[i]),
                .db         (db_o[i]),
                .rise       (rise_o[i]),
                .fall       (fall_o[i]),
                .change_nxt (chg_nxt[i])
            );
        end
    endgenerate

    // Registered from the channels' next-pulse terms so it lines up with rise_o/fall_o.
    always_ff @(posedge clk) begin
        if (rst) any_change_o <= 1'b0;
        else     any_change_o <= |chg_nxt;
    end

endmodule
